// File: rtl/adder_tb_pkg.sv
// Shared constants and state encoding for the adder response monitor.
package adder_tb_pkg;

  localparam int unsigned ADDER_WIDTH     = 16;
  localparam logic [15:0] ADDER_MISR_POLY = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } mon_state_t;

  function automatic logic state_active(input mon_state_t s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/adder_resp_misr.sv
// Multiple-input signature register folding each compared adder response
// (sum plus carry-out on bit 0) into a running signature.
module adder_resp_misr
  import adder_tb_pkg::*;
#(
  parameter int unsigned      WIDTH = ADDER_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(ADDER_MISR_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  input  logic             cin,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] r_sig;
  logic [WIDTH-1:0] w_sig_nxt;

  always_comb begin
    w_sig_nxt = {r_sig[WIDTH-2:0], 1'b0} ^ data ^ {{(WIDTH-1){1'b0}}, cin};
    if (r_sig[WIDTH-1]) begin
      w_sig_nxt = w_sig_nxt ^ POLY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sig <= '0;
    end else if (clear) begin
      r_sig <= '0;
    end else if (en) begin
      r_sig <= w_sig_nxt;
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/adder_resp_monitor.sv
// Response-capture stage for the adder under test: realigns a golden sum to
// the adder latency, compares each pattern and accumulates counts and a MISR.
module adder_resp_monitor
  import adder_tb_pkg::*;
#(
  parameter int unsigned      WIDTH     = ADDER_WIDTH,
  parameter int unsigned      LATENCY   = 1,
  parameter int unsigned      PATTERNS  = 128,
  parameter logic [WIDTH-1:0] MISR_POLY = WIDTH'(ADDER_MISR_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      pat_count,
  output logic [15:0]      err_count,
  output logic [15:0]      first_err_idx,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] signature
);

  localparam logic [15:0] LP_PATTERNS = 16'(PATTERNS);

  mon_state_t r_state;
  mon_state_t w_state_nxt;

  logic [15:0]    r_issued;
  logic [15:0]    r_pat_count;
  logic [15:0]    r_err_count;
  logic [15:0]    r_first_err_idx;
  logic           r_first_err_valid;

  logic           w_run_start;
  logic           w_issue;
  logic           w_cmp_v;
  logic           w_cmp_fire;
  logic           w_last_cmp;
  logic           w_mismatch;
  logic           w_done;
  logic [WIDTH:0] w_exp_now;
  logic [WIDTH:0] w_cmp_exp;
  logic [WIDTH-1:0] w_sig;

  assign w_run_start = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_issue     = (r_state == ST_RUN) && in_valid && (r_issued != LP_PATTERNS);
  assign w_exp_now   = {1'b0, a} + {1'b0, b};

  // Golden-sum alignment: the compare point sits LATENCY stages after issue,
  // or is the current-cycle sum when the adder is combinational.
  if (LATENCY == 0) begin : g_lat0
    assign w_cmp_v   = w_issue;
    assign w_cmp_exp = w_exp_now;
  end else begin : g_pipe
    logic [LATENCY-1:0] r_v;
    logic [WIDTH:0]     r_d [LATENCY];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_v <= '0;
        for (int unsigned i = 0; i < LATENCY; i++) begin
          r_d[i] <= '0;
        end
      end else begin
        r_d[0] <= w_exp_now;
        for (int unsigned i = 1; i < LATENCY; i++) begin
          r_d[i] <= r_d[i-1];
        end
        if (w_run_start) begin
          r_v <= '0;
        end else begin
          r_v[0] <= w_issue;
          for (int unsigned i = 1; i < LATENCY; i++) begin
            r_v[i] <= r_v[i-1];
          end
        end
      end
    end

    assign w_cmp_v   = r_v[LATENCY-1];
    assign w_cmp_exp = r_d[LATENCY-1];
  end

  assign w_cmp_fire = w_cmp_v && state_active(r_state) && (r_pat_count != LP_PATTERNS);
  assign w_last_cmp = w_cmp_fire && (r_pat_count == (LP_PATTERNS - 16'd1));
  assign w_mismatch = ({dut_cout, dut_sum} != w_cmp_exp);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The last compare moves straight to DONE so final counts and done
  // become visible on the same edge, whichever of RUN/DRAIN it lands in.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_last_cmp) begin
          w_state_nxt = ST_DONE;
        end else if (r_issued == LP_PATTERNS) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_last_cmp || (r_pat_count == LP_PATTERNS)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (start) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_issued <= '0;
    end else if (w_run_start) begin
      r_issued <= '0;
    end else if (w_issue) begin
      r_issued <= r_issued + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pat_count       <= '0;
      r_err_count       <= '0;
      r_first_err_idx   <= '0;
      r_first_err_valid <= 1'b0;
    end else if (w_run_start) begin
      r_pat_count       <= '0;
      r_err_count       <= '0;
      r_first_err_idx   <= '0;
      r_first_err_valid <= 1'b0;
    end else if (w_cmp_fire) begin
      r_pat_count <= r_pat_count + 16'd1;
      if (w_mismatch) begin
        if (r_err_count != '1) begin
          r_err_count <= r_err_count + 16'd1;
        end
        if (!r_first_err_valid) begin
          r_first_err_idx   <= r_pat_count;
          r_first_err_valid <= 1'b1;
        end
      end
    end
  end

  adder_resp_misr #(
    .WIDTH (WIDTH),
    .POLY  (MISR_POLY)
  ) u_misr (
    .clk   (clk),
    .rst   (rst),
    .clear (w_run_start),
    .en    (w_cmp_fire),
    .data  (dut_sum),
    .cin   (dut_cout),
    .sig   (w_sig)
  );

  assign w_done          = (r_state == ST_DONE);
  assign busy            = state_active(r_state);
  assign done            = w_done;
  assign pass            = w_done && (r_err_count == '0);
  assign pat_count       = r_pat_count;
  assign err_count       = r_err_count;
  assign first_err_idx   = r_first_err_idx;
  assign first_err_valid = r_first_err_valid;
  assign signature       = w_sig;

endmodule

// File: tb/tb_adder_resp_monitor.sv
// Directed bench: two monitors (latency 1 and 3) fed by a behavioural adder
// with selectable faults, checked against hand-derived results.
module tb_adder_resp_monitor;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  int          fault_mode;

  logic [16:0] r_s1, r_s2, r_s3;
  logic [15:0] sum1, sum3;
  logic        cout1, cout3;

  logic        busy1, done1, pass1, fv1;
  logic [15:0] pc1, ec1, fi1, sig1;
  logic        busy3, done3, pass3, fv3;
  logic [15:0] pc3, ec3, fi3, sig3;

  int n_cmp;
  int n_bad;

  localparam logic [15:0] CORR_A = 16'hF604;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    r_s1 <= ({1'b0, a} + {1'b0, b}) ^ (((fault_mode == 2) && (a == CORR_A)) ? 17'h00001 : 17'h00000);
    r_s2 <= r_s1;
    r_s3 <= r_s2;
  end

  assign sum1  = r_s1[15:0] | ((fault_mode == 1) ? 16'h0008 : 16'h0000);
  assign cout1 = r_s1[16];
  assign sum3  = r_s3[15:0] | ((fault_mode == 1) ? 16'h0008 : 16'h0000);
  assign cout3 = r_s3[16];

  adder_resp_monitor #(
    .WIDTH(16), .LATENCY(1), .PATTERNS(128), .MISR_POLY(16'hB400)
  ) u_dut_l1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .a(a), .b(b),
    .dut_sum(sum1), .dut_cout(cout1), .busy(busy1), .done(done1), .pass(pass1),
    .pat_count(pc1), .err_count(ec1), .first_err_idx(fi1),
    .first_err_valid(fv1), .signature(sig1)
  );

  adder_resp_monitor #(
    .WIDTH(16), .LATENCY(3), .PATTERNS(128), .MISR_POLY(16'hB400)
  ) u_dut_l3 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .a(a), .b(b),
    .dut_sum(sum3), .dut_cout(cout3), .busy(busy3), .done(done3), .pass(pass3),
    .pat_count(pc3), .err_count(ec3), .first_err_idx(fi3),
    .first_err_valid(fv3), .signature(sig3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] misr_ref(input logic [15:0] d, input int bad_idx,
                                           input logic [15:0] bad_d);
    logic [15:0] s;
    logic [15:0] x;
    s = '0;
    for (int i = 0; i < 128; i++) begin
      x = (i == bad_idx) ? bad_d : d;
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'hB400 : 16'h0000) ^ x ^ 16'h0001;
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_sweep(input int n, input bit gaps, input int start_at);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      a        = 16'(65535 - i * 511);
      b        = 16'(1 + i * 511);
      start    = (i == start_at);
      tick();
      start = 1'b0;
      if (gaps) begin
        in_valid = 1'b0;
        a        = 16'h1234;
        b        = 16'h4321;
        tick();
      end
    end
    in_valid = 1'b0;
    a        = 16'h0000;
    b        = 16'h0000;
  endtask

  task automatic wait_done();
    for (int c = 0; c < 100; c++) begin
      if (done1 && done3) break;
      tick();
    end
    check("done_timeout", {30'd0, done1, done3}, 32'h3);
  endtask

  task automatic check_results(input string p, input logic [15:0] e_err, input logic e_fv,
                               input logic [15:0] e_fi, input logic [15:0] e_sig);
    check({p, "_l1_pat"},  pc1,  32'd128);
    check({p, "_l1_err"},  ec1,  {16'd0, e_err});
    check({p, "_l1_pass"}, pass1, (e_err == 16'd0));
    check({p, "_l1_fv"},   fv1,  e_fv);
    check({p, "_l1_fi"},   fi1,  {16'd0, e_fi});
    check({p, "_l1_sig"},  sig1, {16'd0, e_sig});
    check({p, "_l1_busy"}, busy1, 1'b0);
    check({p, "_l3_pat"},  pc3,  32'd128);
    check({p, "_l3_err"},  ec3,  {16'd0, e_err});
    check({p, "_l3_pass"}, pass3, (e_err == 16'd0));
    check({p, "_l3_fv"},   fv3,  e_fv);
    check({p, "_l3_fi"},   fi3,  {16'd0, e_fi});
    check({p, "_l3_sig"},  sig3, {16'd0, e_sig});
  endtask

  task automatic check_zero(input string p);
    check({p, "_l1_flags"}, {busy1, done1, pass1, fv1}, 4'h0);
    check({p, "_l1_cnt"},   {pc1, ec1}, 32'h0);
    check({p, "_l1_fisig"}, {fi1, sig1}, 32'h0);
    check({p, "_l3_flags"}, {busy3, done3, pass3, fv3}, 4'h0);
    check({p, "_l3_cnt"},   {pc3, ec3}, 32'h0);
    check({p, "_l3_fisig"}, {fi3, sig3}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] sig_ok, sig_stuck, sig_one;
    n_cmp      = 0;
    n_bad      = 0;
    fault_mode = 0;
    rst        = 1'b1;
    start      = 1'b0;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    sig_ok     = misr_ref(16'h0000, -1, 16'h0000);
    sig_stuck  = misr_ref(16'h0008, -1, 16'h0000);
    sig_one    = misr_ref(16'h0000, 5, 16'h0001);

    #3 rst = 1'b0;
    #2;
    check_zero("reset");
    tick();
    tick();
    rst = 1'b1;
    tick();

    // 1: clean sweep, latency 1 timing of done
    pulse_start();
    check("s1_busy_after_start", busy1, 1'b1);
    drive_sweep(128, 1'b0, -1);
    check("s1_l1_pat_before_last", pc1, 32'd127);
    check("s1_l1_done_early", done1, 1'b0);
    tick();
    check("s1_l1_done_rise", done1, 1'b1);
    check("s1_l1_pat_at_done", pc1, 32'd128);
    wait_done();
    check_results("s1", 16'd0, 1'b0, 16'd0, sig_ok);

    // 2: sum bit 3 stuck at 1
    fault_mode = 1;
    pulse_start();
    drive_sweep(128, 1'b0, -1);
    wait_done();
    check_results("s2", 16'd128, 1'b1, 16'd0, sig_stuck);

    // 3: single corruption at pattern 5
    fault_mode = 2;
    pulse_start();
    drive_sweep(128, 1'b0, -1);
    wait_done();
    check_results("s3", 16'd1, 1'b1, 16'd5, sig_one);
    fault_mode = 0;

    // 4: in_valid every other cycle, latency 3 drain timing
    pulse_start();
    drive_sweep(128, 1'b1, -1);
    tick();
    check("s4_l3_pat_before_last", pc3, 32'd127);
    check("s4_l3_done_early", done3, 1'b0);
    tick();
    check("s4_l3_done_rise", done3, 1'b1);
    wait_done();
    check_results("s4", 16'd0, 1'b0, 16'd0, sig_ok);

    // 5: async reset mid-run, then a full clean run
    pulse_start();
    drive_sweep(41, 1'b0, -1);
    check("s5_l1_pat_pre_rst", pc1, 32'd40);
    #2 rst = 1'b0;
    #1;
    check_zero("s5_rst");
    #2 rst = 1'b1;
    tick();
    tick();
    check_zero("s5_idle");
    pulse_start();
    drive_sweep(128, 1'b0, -1);
    wait_done();
    check_results("s5", 16'd0, 1'b0, 16'd0, sig_ok);

    // 6: start during RUN ignored, 140 patterns offered, then restart from DONE
    pulse_start();
    drive_sweep(140, 1'b0, 20);
    wait_done();
    check_results("s6", 16'd0, 1'b0, 16'd0, sig_ok);
    fault_mode = 1;
    pulse_start();
    check("s6_restart_busy", {busy1, done1, busy3, done3}, 4'b1010);
    check("s6_restart_cnt", {pc1, sig1}, 32'h0);
    drive_sweep(128, 1'b0, -1);
    wait_done();
    check_results("s6r", 16'd128, 1'b1, 16'd0, sig_stuck);
    fault_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
